// File: rtl/fb_pkg.sv
`default_nettype none
// ============================================================================
// Module : fb_pkg
// Brief  : Shared frame-buffer geometry, pixel type and arbiter state encoding.
// Rev    : 1.0 - initial release
// ============================================================================
package fb_pkg;

    localparam int FB_WIDTH  = 320;
    localparam int FB_HEIGHT = 180;
    localparam int FB_DEPTH  = FB_WIDTH * FB_HEIGHT;

    typedef logic [15:0] pixel_t;

    typedef enum logic [0:0] {
        ST_ARB   = 1'b0,
        ST_CLEAR = 1'b1
    } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/rr_arbiter2.sv
`default_nettype none
// ============================================================================
// Module : rr_arbiter2
// Brief  : Two-requester round-robin arbiter with a last-grant pointer.
// Rev    : 1.0 - initial release
// ============================================================================
module rr_arbiter2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] i_req,
    input  logic       i_update,
    output logic [1:0] o_grant
);

    // High when requester 1 won the most recent transfer; reset favours requester 0.
    logic r_last_hi;

    always_comb begin
        o_grant = i_req;
        if (i_req == 2'b11) begin
            o_grant = r_last_hi ? 2'b01 : 2'b10;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_hi <= 1'b1;
        end else if (i_update) begin
            r_last_hi <= o_grant[1];
        end
    end

endmodule
`default_nettype wire

// File: rtl/fb_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module : fb_write_arbiter
// Brief  : Arbitrates CPU and blitter pixel writes and performs full-frame fills.
// Rev    : 1.0 - initial release
// ============================================================================
module fb_write_arbiter #(
    parameter int FB_DEPTH   = fb_pkg::FB_DEPTH,
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  cpu_valid,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [DATA_WIDTH-1:0] cpu_data,
    output logic                  cpu_ready,
    input  logic                  gpu_valid,
    input  logic [ADDR_WIDTH-1:0] gpu_addr,
    input  logic [DATA_WIDTH-1:0] gpu_data,
    output logic                  gpu_ready,
    input  logic                  clear_start,
    input  logic [DATA_WIDTH-1:0] clear_color,
    output logic                  clear_busy,
    output logic                  clear_done,
    output logic                  fb_we,
    output logic [ADDR_WIDTH-1:0] fb_addr,
    output logic [DATA_WIDTH-1:0] fb_data,
    output logic                  addr_err
);

    import fb_pkg::*;

    localparam logic [ADDR_WIDTH:0]   c_DEPTH_EXT = (ADDR_WIDTH + 1)'(FB_DEPTH);
    localparam logic [ADDR_WIDTH-1:0] c_LAST_ADDR = ADDR_WIDTH'(FB_DEPTH - 1);

    arb_state_t            r_state;
    arb_state_t            w_state_nxt;
    logic [ADDR_WIDTH-1:0] r_clr_cnt;
    logic [ADDR_WIDTH-1:0] w_clr_cnt_nxt;
    logic [DATA_WIDTH-1:0] r_color;
    logic [DATA_WIDTH-1:0] w_color_nxt;
    logic                  r_fb_we;
    logic                  w_fb_we_nxt;
    logic [ADDR_WIDTH-1:0] r_fb_addr;
    logic [ADDR_WIDTH-1:0] w_fb_addr_nxt;
    logic [DATA_WIDTH-1:0] r_fb_data;
    logic [DATA_WIDTH-1:0] w_fb_data_nxt;
    logic                  r_addr_err;
    logic                  w_addr_err_nxt;
    logic                  r_clear_done;
    logic                  w_clear_done_nxt;

    logic [1:0]            w_grant;
    logic                  w_arb_open;
    logic                  w_xfer;
    logic                  w_oor;
    logic [ADDR_WIDTH-1:0] w_sel_addr;
    logic [DATA_WIDTH-1:0] w_sel_data;

    rr_arbiter2 u_rr (
        .clk      (clk_in),
        .rst      (rst_in),
        .i_req    ({gpu_valid, cpu_valid}),
        .i_update (w_xfer),
        .o_grant  (w_grant)
    );

    // A pending fill request closes the arbitration window for this cycle.
    assign w_arb_open = !rst_in && (r_state == ST_ARB) && !clear_start;
    assign cpu_ready  = w_arb_open && w_grant[0];
    assign gpu_ready  = w_arb_open && w_grant[1];
    assign w_xfer     = (cpu_valid && cpu_ready) || (gpu_valid && gpu_ready);
    assign w_sel_addr = w_grant[1] ? gpu_addr : cpu_addr;
    assign w_sel_data = w_grant[1] ? gpu_data : cpu_data;
    assign w_oor      = {1'b0, w_sel_addr} >= c_DEPTH_EXT;

    always_comb begin
        w_state_nxt      = r_state;
        w_clr_cnt_nxt    = r_clr_cnt;
        w_color_nxt      = r_color;
        w_fb_we_nxt      = 1'b0;
        w_fb_addr_nxt    = r_fb_addr;
        w_fb_data_nxt    = r_fb_data;
        w_addr_err_nxt   = 1'b0;
        w_clear_done_nxt = 1'b0;
        case (r_state)
            ST_ARB: begin
                if (clear_start) begin
                    // Present address 0 in the first CLEAR cycle.
                    w_state_nxt   = ST_CLEAR;
                    w_color_nxt   = clear_color;
                    w_clr_cnt_nxt = '0;
                    w_fb_we_nxt   = 1'b1;
                    w_fb_addr_nxt = '0;
                    w_fb_data_nxt = clear_color;
                end else if (w_xfer) begin
                    w_fb_we_nxt    = !w_oor;
                    w_addr_err_nxt = w_oor;
                    w_fb_addr_nxt  = w_sel_addr;
                    w_fb_data_nxt  = w_sel_data;
                end
            end
            ST_CLEAR: begin
                if (r_clr_cnt == c_LAST_ADDR) begin
                    w_state_nxt      = ST_ARB;
                    w_clear_done_nxt = 1'b1;
                end else begin
                    w_clr_cnt_nxt = r_clr_cnt + ADDR_WIDTH'(1);
                    w_fb_we_nxt   = 1'b1;
                    w_fb_addr_nxt = r_clr_cnt + ADDR_WIDTH'(1);
                    w_fb_data_nxt = r_color;
                end
            end
            default: begin
                w_state_nxt = ST_ARB;
            end
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_state <= ST_ARB;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_clr_cnt    <= '0;
            r_color      <= '0;
            r_fb_we      <= 1'b0;
            r_fb_addr    <= '0;
            r_fb_data    <= '0;
            r_addr_err   <= 1'b0;
            r_clear_done <= 1'b0;
        end else begin
            r_clr_cnt    <= w_clr_cnt_nxt;
            r_color      <= w_color_nxt;
            r_fb_we      <= w_fb_we_nxt;
            r_fb_addr    <= w_fb_addr_nxt;
            r_fb_data    <= w_fb_data_nxt;
            r_addr_err   <= w_addr_err_nxt;
            r_clear_done <= w_clear_done_nxt;
        end
    end

    assign clear_busy = (r_state == ST_CLEAR);
    assign clear_done = r_clear_done;
    assign fb_we      = r_fb_we;
    assign fb_addr    = r_fb_addr;
    assign fb_data    = r_fb_data;
    assign addr_err   = r_addr_err;

endmodule
`default_nettype wire

// File: doc/fb_write_arbiter.md
FB_WRITE_ARBITER -- requirements
Module: fb_write_arbiter

Interface
REQ-001 SHALL have parameter FB_DEPTH, default 57600: frame buffer pixel count (320x180).
REQ-002 SHALL have parameter ADDR_WIDTH, default 16: pixel address width.
REQ-003 SHALL have parameter DATA_WIDTH, default 16: pixel width (RGB565).
REQ-004 SHALL have one clock and a synchronous, active-high reset: clk_in input 1 system clock; rst_in input 1 reset.
REQ-005 SHALL have cpu_valid, cpu_addr[ADDR_WIDTH], cpu_data[DATA_WIDTH] inputs and cpu_ready output: memory-system write request channel.
REQ-006 SHALL have gpu_valid, gpu_addr[ADDR_WIDTH], gpu_data[DATA_WIDTH] inputs and gpu_ready output: blitter write request channel.
REQ-007 SHALL have clear_start input 1 (start fill), clear_color input DATA_WIDTH (fill value), clear_busy output 1, clear_done output 1 (one-cycle pulse).
REQ-008 SHALL have fb_we output 1, fb_addr output ADDR_WIDTH, fb_data output DATA_WIDTH: frame buffer write port.
REQ-009 SHALL have addr_err output 1: one-cycle pulse when an accepted request is out of range.

Function
REQ-010 SHALL implement FSM states ARB and CLEAR.
REQ-011 ARB: grant the sole valid requester; if both are valid, grant the one not granted last (round-robin); last-grant pointer resets to GPU, so CPU wins the first tie.
REQ-012 SHALL assert ready only to the granted requester, only in ARB, and only when clear_start is low; ready may depend on valid, and valid shall not depend on ready.
REQ-013 A transfer occurs when valid && ready; at most one transfer per cycle; the last-grant pointer updates only on a transfer.
REQ-014 Write latency: on a transfer in cycle N, fb_we=1 with the captured addr/data in cycle N+1; all fb_* outputs are registered.
REQ-015 An accepted request with addr >= FB_DEPTH SHALL be consumed with fb_we=0 in cycle N+1 and addr_err=1 in cycle N+1.
REQ-016 clear_start high in ARB SHALL take priority over both requesters: no transfer that cycle; latch clear_color; enter CLEAR next cycle with clear_busy=1.
REQ-017 CLEAR: one write per cycle, fb_addr 0, 1, ..., FB_DEPTH-1, fb_data=latched color, fb_we=1; the sequence takes exactly FB_DEPTH cycles.
REQ-018 In CLEAR, cpu_ready=gpu_ready=0; pending requests stall and are not dropped.
REQ-019 After the write to FB_DEPTH-1: clear_done=1 for one cycle, clear_busy=0 in the same cycle, return to ARB; requests become eligible in that cycle.
REQ-020 clear_start in CLEAR SHALL be ignored (no restart, no color change).
REQ-021 fb_we SHALL be 0 in every cycle with no transfer and no clear write.
REQ-022 The clear address counter SHALL not wrap: terminal compare uses FB_DEPTH-1; counter width is ADDR_WIDTH.

Reset
REQ-023 rst_in SHALL force state ARB, last-grant pointer GPU, fb_we=0, fb_addr=0, fb_data=0, ready outputs 0, clear_busy=0, clear_done=0, addr_err=0, clear counter 0.
REQ-024 rst_in during CLEAR SHALL abort the clear without asserting clear_done; the captured request pipeline stage is discarded.

Structure
REQ-025 FB_WIDTH, FB_HEIGHT, FB_DEPTH, pixel_t and the arbiter state enum SHALL live in shared package fb_pkg.
REQ-026 The round-robin grant logic SHALL be a sub-module rr_arbiter2 (two requesters, pointer, grant one-hot).

Verification
REQ-027 CPU-only writes: cpu addr 0x0010 data 0xF800 -> ready same cycle; fb_we=1, fb_addr=0x0010, fb_data=0xF800 one cycle later.
REQ-028 Both valid, held 4 cycles after reset -> grants CPU, GPU, CPU, GPU; fb_we high on 4 consecutive cycles.
REQ-029 clear_start with color 0x001F while cpu_valid=1 -> cpu_ready=0 for FB_DEPTH+1 cycles; 57600 writes of 0x001F to addresses 0..57599; clear_done pulses once; the CPU write is then serviced.
REQ-030 GPU write to addr 57600 -> gpu_ready=1; next cycle fb_we=0 and addr_err=1.
REQ-031 rst_in asserted at clear address 1000 -> next cycle all outputs at reset values; clear_done is never pulsed; ARB resumes.
REQ-032 clear_start pulsed mid-clear -> no restart; total clear length stays FB_DEPTH cycles.
